// File: rtl/load_store_queue_ring.sv
// Circular load/store queue: in-order dispatch, in-order commit, oldest-first drain.
// Optional store-to-load forwarding search enabled by defining LSQ_STORE_FWD_EN.
module load_store_queue_ring #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ENTRIES        = 16
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic                        clk_en,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic                        push_is_store,
  input  logic [MEM_ADDR_WIDTH-1:0]   push_addr,
  input  logic [DATA_WIDTH-1:0]       push_data,
  output logic [$clog2(ENTRIES)-1:0]  push_idx,
  input  logic                        commit,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_is_store,
  output logic [MEM_ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(ENTRIES):0]    count,
  output logic                        empty,
  output logic                        full
`ifdef LSQ_STORE_FWD_EN
  ,
  input  logic [MEM_ADDR_WIDTH-1:0]   ld_lookup_addr,
  output logic                        fwd_hit,
  output logic [DATA_WIDTH-1:0]       fwd_data
`endif
);

  localparam int IDX_WIDTH = $clog2(ENTRIES);
  localparam logic [IDX_WIDTH:0] PTR_ONE = {{IDX_WIDTH{1'b0}}, 1'b1};

  logic [IDX_WIDTH:0]      head, cmt, tail, cmt_next;
  logic                    do_push, do_commit, do_pop;
  logic                    st_is_store [ENTRIES];
  logic [MEM_ADDR_WIDTH-1:0] st_addr   [ENTRIES];
  logic [DATA_WIDTH-1:0]   st_data     [ENTRIES];

  assign full  = (head[IDX_WIDTH] != tail[IDX_WIDTH]) &&
                 (head[IDX_WIDTH-1:0] == tail[IDX_WIDTH-1:0]);
  assign empty = (head == tail);
  assign count = tail - head;

  assign push_ready = !full && !flush;
  assign push_idx   = tail[IDX_WIDTH-1:0];
  assign out_valid  = (head != cmt);

  assign out_is_store = st_is_store[head[IDX_WIDTH-1:0]];
  assign out_addr     = st_addr[head[IDX_WIDTH-1:0]];
  assign out_data     = st_data[head[IDX_WIDTH-1:0]];

  // All qualifiers are judged on pre-edge state, so a same-cycle push is never committable.
  assign do_push   = push_valid && push_ready && clk_en;
  assign do_commit = commit && (cmt != tail) && clk_en;
  assign do_pop    = out_valid && out_ready && clk_en;
  assign cmt_next  = do_commit ? cmt + PTR_ONE : cmt;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        st_is_store[i] <= 1'b0;
        st_addr[i]     <= '0;
        st_data[i]     <= '0;
      end
    end else if (clk_en) begin
      if (do_push) begin
        st_is_store[tail[IDX_WIDTH-1:0]] <= push_is_store;
        st_addr[tail[IDX_WIDTH-1:0]]     <= push_addr;
        st_data[tail[IDX_WIDTH-1:0]]     <= push_data;
      end
      if (do_pop) head <= head + PTR_ONE;
      cmt <= cmt_next;
      if (flush)        tail <= cmt_next;
      else if (do_push) tail <= tail + PTR_ONE;
    end
  end

`ifdef LSQ_STORE_FWD_EN
  // Walk oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    logic [IDX_WIDTH-1:0] slot;
    logic [IDX_WIDTH:0]   off;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    off      = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      off  = i[IDX_WIDTH:0];
      slot = head[IDX_WIDTH-1:0] + i[IDX_WIDTH-1:0];
      if ((off < count) && st_is_store[slot] && (st_addr[slot] == ld_lookup_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = st_data[slot];
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_queue_ring.sv
// Self-checking bench for load_store_queue_ring (ENTRIES=4) against a queue-based model.
// Forwarding checks are compiled in when LSQ_STORE_FWD_EN is defined.
module tb_load_store_queue_ring;
  localparam int ENT = 4;

  logic        clk = 1'b0;
  logic        sync_rst, clk_en, push_valid, push_ready, push_is_store;
  logic [31:0] push_addr, push_data, out_addr, out_data;
  logic [1:0]  push_idx;
  logic        commit, flush, out_valid, out_ready, out_is_store, empty, full;
  logic [2:0]  count;
`ifdef LSQ_STORE_FWD_EN
  logic [31:0] ld_lookup_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  load_store_queue_ring #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .ENTRIES(ENT)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .push_valid(push_valid), .push_ready(push_ready), .push_is_store(push_is_store),
    .push_addr(push_addr), .push_data(push_data), .push_idx(push_idx),
    .commit(commit), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_store(out_is_store),
    .out_addr(out_addr), .out_data(out_data),
    .count(count), .empty(empty), .full(full)
`ifdef LSQ_STORE_FWD_EN
    , .ld_lookup_addr(ld_lookup_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   ncmt = 0;
  int   hs   = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == ENT));
    chk("push_ready", 64'(push_ready), 64'((q.size() != ENT) && !flush));
    chk("push_idx", 64'(push_idx), 64'((hs + q.size()) % ENT));
    chk("out_valid", 64'(out_valid), 64'(ncmt > 0));
    if (ncmt > 0) begin
      chk("out_addr", 64'(out_addr), 64'(q[0].a));
      chk("out_is_store", 64'(out_is_store), 64'(q[0].st));
      if (q[0].st) chk("out_data", 64'(out_data), 64'(q[0].d));
    end
`ifdef LSQ_STORE_FWD_EN
    begin
      bit          h = 1'b0;
      logic [31:0] d = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (!h && q[i].st && q[i].a == ld_lookup_addr) begin
          h = 1'b1;
          d = q[i].d;
        end
      chk("fwd_hit", 64'(fwd_hit), 64'(h));
      chk("fwd_data", 64'(fwd_data), 64'(d));
    end
`endif
  endtask

  task automatic step(input bit rst, input bit en, input bit pv, input bit ps,
                      input logic [31:0] pa, input logic [31:0] pd,
                      input bit cm, input bit fl, input bit ordy);
    bit acc, cok, pop;
    ent_t e;
    sync_rst = rst; clk_en = en; push_valid = pv; push_is_store = ps;
    push_addr = pa; push_data = pd; commit = cm; flush = fl; out_ready = ordy;
    #1;
    check_model();
    @(posedge clk);
    if (rst) begin
      q.delete(); ncmt = 0; hs = 0;
    end else if (en) begin
      acc = pv && (q.size() != ENT) && !fl;
      cok = cm && (ncmt < q.size());
      pop = (ncmt > 0) && ordy;
      if (cok) ncmt++;
      if (pop) begin
        void'(q.pop_front());
        ncmt--;
        hs = (hs + 1) % ENT;
      end
      if (fl) while (q.size() > ncmt) void'(q.pop_back());
      if (acc) begin
        e.st = ps; e.a = pa; e.d = pd;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 1, 0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    sync_rst = 1'b1; clk_en = 1'b0; push_valid = 1'b0; push_is_store = 1'b0;
    push_addr = '0; push_data = '0; commit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    sync_rst = 1'b0; #1;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_is_store", 64'(out_is_store), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_push_idx", 64'(push_idx), 64'd0);

    // Fill the queue with out_ready low
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; #1;
      chk("fill_push_idx", 64'(push_idx), 64'(i));
      step(0, 1, 1, i[0], 32'h10 + 32'(4 * i), 32'h100 + 32'(i), 0, 0, 0);
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_push_ready", 64'(push_ready), 64'd0);
    chk("fill_out_valid", 64'(out_valid), 64'd0);
    step(0, 1, 1, 0, 32'h99, '0, 0, 0, 0);   // refused push when full

    // Commit two, then drain them
    step(0, 1, 0, 0, '0, '0, 1, 0, 0);
    chk("cmt1_out_valid", 64'(out_valid), 64'd1);
    chk("cmt1_out_addr", 64'(out_addr), 64'h10);
    step(0, 1, 0, 0, '0, '0, 1, 0, 0);
    step(0, 1, 0, 0, '0, '0, 0, 0, 1);
    chk("pop1_out_addr", 64'(out_addr), 64'h14);
    step(0, 1, 0, 0, '0, '0, 0, 0, 1);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd2);

    // Continuous stream across pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 1, 32'h200 + 32'(4 * i), 32'(i), 1, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0, '0, 1, 0, 1);
    chk("stream_empty", 64'(empty), 64'd1);

    // Flush with same-cycle commit
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h300 + 32'(i), '0, 0, 0, 0);
    step(0, 1, 0, 0, '0, '0, 1, 0, 0);
    step(0, 1, 1, 0, 32'h3FF, '0, 1, 1, 0);
    chk("flush_count", 64'(count), 64'd2);
    chk("flush_push_idx", 64'(push_idx), 64'd2);
    idle();

    // clk_en low freezes everything, then mid-stream reset
    step(0, 1, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h400, 32'h1, 1, 0, 1);
    chk("frz_count", 64'(count), 64'd2);
    chk("frz_push_idx", 64'(push_idx), 64'd2);
    step(0, 1, 1, 1, 32'h404, 32'h2, 1, 0, 0);
    step(1, 0, 1, 1, 32'h408, 32'h3, 1, 0, 1);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    idle();

`ifdef LSQ_STORE_FWD_EN
    step(0, 1, 1, 1, 32'h40, 32'hA, 0, 0, 0);
    step(0, 1, 1, 1, 32'h40, 32'hB, 0, 0, 0);
    ld_lookup_addr = 32'h40; #1;
    chk("fwd40_hit", 64'(fwd_hit), 64'd1);
    chk("fwd40_data", 64'(fwd_data), 64'hB);
    ld_lookup_addr = 32'h44; #1;
    chk("fwd44_hit", 64'(fwd_hit), 64'd0);
    chk("fwd44_data", 64'(fwd_data), 64'd0);
    idle();
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
`ifdef LSQ_STORE_FWD_EN
      ld_lookup_addr = 32'h40 + 32'(4 * $urandom_range(0, 3));
`endif
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           32'h40 + 32'(4 * $urandom_range(0, 3)), $urandom(),
           $urandom_range(0, 2) != 0, ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_queue_ring.md
Name: load_store_queue_ring

Overview:
- Parametrised successor to the single-slot load/store queue.
- Circular buffer of ENTRIES memory ops: allocated in program order at dispatch, marked committed in order by retirement, drained oldest-first to the memory port via valid/ready.
- Adds full/empty/occupancy tracking, in-order commit, flush of speculative (uncommitted) entries and backpressure.
- Sits between dispatch/ROB and the data-memory interface.

Parameters:
- MEM_ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, store data width.
- ENTRIES, 16, queue depth; power of two, at least 2.
- Derived localparam IDX_WIDTH = $clog2(ENTRIES); pointers are IDX_WIDTH+1 bits (wrap bit).

Ports:
- clk  in  1  clock.
- sync_rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  global enable; state frozen when low.
- push_valid  in  1  dispatch presents an op.
- push_ready  out  1  queue can accept (= !full && !flush).
- push_is_store  in  1  0 = load, 1 = store.
- push_addr  in  MEM_ADDR_WIDTH  op address.
- push_data  in  DATA_WIDTH  store data (don't-care for loads).
- push_idx  out  IDX_WIDTH  slot the current push will occupy (tail).
- commit  in  1  retire oldest uncommitted entry.
- flush  in  1  discard all uncommitted entries.
- out_valid  out  1  head entry is valid and committed.
- out_ready  in  1  memory accepts head.
- out_is_store  out  1  head op type.
- out_addr  out  MEM_ADDR_WIDTH  head address.
- out_data  out  DATA_WIDTH  head data.
- count  out  IDX_WIDTH+1  valid entries.
- empty  out  1  count == 0.
- full  out  1  count == ENTRIES.

Behaviour:
- State: head, cmt and tail pointers (IDX_WIDTH+1 bits) plus per-entry {is_store, addr, data}. Invariant: head <= cmt <= tail in modular order. Entries [head, cmt) are committed; [cmt, tail) are speculative.
- Reset (sync_rst high at clk edge, regardless of clk_en): all pointers 0, entry storage 0. Resulting outputs: count 0, empty 1, full 0, out_valid 0, out_* 0, push_ready 1, push_idx 0. Reset mid-operation drops everything, committed entries included.
- clk_en low: no pointer or storage update. Outputs keep reflecting current state; no transfer counts as accepted.
- Push: push_valid && push_ready && clk_en. Write slot tail[IDX_WIDTH-1:0]; tail++ next cycle. push_idx is combinational from tail.
- Commit: commit && (cmt != tail) && clk_en → cmt++. Ignored when there are no speculative entries, judged on pre-edge state; an entry pushed in the same cycle cannot be committed that cycle.
- Drain:
  - out_valid = (head != cmt), combinational from registered state; out_* driven from slot head.
  - Pop on out_valid && out_ready && clk_en → head++.
  - Zero-cycle latency from commit-visible to out_valid: a commit at edge N gives out_valid in cycle N+1.
- Flush: flush && clk_en → tail <= cmt_next, where cmt_next includes any same-cycle commit. A same-cycle push is not accepted (push_ready low). A same-cycle pop still occurs.
- Simultaneous push and pop when full: push refused; push_ready is from pre-edge state.
- count = tail - head, full/empty from pointer compare: equal index with differing wrap bit = full, identical = empty.
- Pointer wrap: index bits roll ENTRIES-1 → 0 and the wrap bit toggles.

Optional Feature:
- Macro: LSQ_STORE_FWD_EN.
- Defined: adds inputs ld_lookup_addr (MEM_ADDR_WIDTH) and outputs fwd_hit (1), fwd_data (DATA_WIDTH).
  - Combinational search of all valid entries [head, tail) for stores with addr == ld_lookup_addr; the youngest match (nearest tail) wins.
  - fwd_hit = 1 with its data; otherwise fwd_hit = 0, fwd_data = 0.
  - Entries being pushed in the same cycle are not searched.
- Undefined: these ports and the search logic do not exist.

Test Plan (ENTRIES=4):
- Reset, push 4 ops (addr 0x10,0x14,0x18,0x1C) with out_ready=0 → push_idx 0..3, count=4, full=1, push_ready=0, out_valid=0.
- Then commit ×2 → out_valid=1 with addr 0x10; out_ready=1 pops 0x10, then 0x14, then out_valid=0; count=2.
- Push, commit, pop continuously for 10 ops → addresses emerge in order across pointer wrap, empty=1 at end.
- 3 pushes, commit ×1, then flush + commit in the same cycle → count=2 (two committed entries), tail = cmt, next push_idx = 2.
- clk_en=0 with push_valid, commit, out_ready all high → no state change; sync_rst mid-stream → count=0, out_valid=0 next cycle.
- LSQ_STORE_FWD_EN: stores to 0x40 (data 0xA), then 0x40 (0xB); lookup 0x40 → fwd_hit=1, fwd_data=0xB; lookup 0x44 → fwd_hit=0.
